// File: rtl/vga_pkg.sv
// Shared VGA definitions for the overlay blocks: active-region size,
// counter widths, the default colour width and a packed RGB type.
// No ports; imported by flash_timer and char_string_renderer.
package vga_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 400;
  localparam int PIX_W         = 10;   // pixel counter width (0..639)
  localparam int LINE_W        = 9;    // line counter width (0..399)
  localparam int DEFAULT_RGB_W = 9;    // 3 bits per channel

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int ceilLog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_timer.sv
// Frame-start detector plus frame counter and flash phase, shared by the
// overlay blocks.
// Ports:
//   clock, reset         pixel clock, asynchronous active-high reset
//   pixelCnt, lineCnt    active-region counters from the timing generator
//   frameStart           combinational, high on pixel 0 of line 0
//   flashPhase           toggles every FLASH_FRAMES frame starts
module flash_timer
  import vga_pkg::*;
#(
  parameter int FLASH_FRAMES = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pixelCnt,
  input  logic [LINE_W-1:0] lineCnt,
  output logic              frameStart,
  output logic              flashPhase
);

  localparam int               CNT_W = ceilLog2(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FLASH_FRAMES - 1);

  logic [CNT_W-1:0] frameCnt;

  assign frameStart = (pixelCnt == '0) && (lineCnt == '0);

  // Runs whether or not any consumer has flashing enabled, so every overlay
  // sharing this timer blinks in step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frameCnt   <= '0;
      flashPhase <= 1'b0;
    end else if (frameStart) begin
      if (frameCnt == LAST) begin
        frameCnt   <= '0;
        flashPhase <= ~flashPhase;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/char_string_renderer.sv
// Renders a COLS-glyph string from an external glyph ROM into the VGA
// active region at a programmable position with 1x/2x/4x/8x magnification.
// Latency from pixelCnt/lineCnt to vgaRGB is ROM_LAT+2 cycles.
// Ports:
//   clock, reset         pixel clock, asynchronous active-high reset
//   pixelCnt, lineCnt    active-region counters
//   xPos, yPos, mag      box position and magnification exponent
//   flashEn              enable per-frame flashing of foreground pixels
//   charRgb, bkRgb       foreground / background colours
//   romSlot, romRow      glyph ROM address (character slot, glyph row)
//   romData              glyph row, MSB leftmost, ROM_LAT cycles after address
//   vgaRGB               registered pixel colour
// Build option CURSOR_EN adds cursorSlot/cursorOn: the last glyph row of the
// cursor slot is forced to foreground, blinking with flashPhase.
module char_string_renderer
  import vga_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int RGB_W        = DEFAULT_RGB_W,
  parameter int ROM_LAT      = 2,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PIX_W-1:0]           pixelCnt,
  input  logic [LINE_W-1:0]          lineCnt,
  input  logic [PIX_W-1:0]           xPos,
  input  logic [LINE_W-1:0]          yPos,
  input  logic [1:0]                 mag,
  input  logic                       flashEn,
  input  logic [RGB_W-1:0]           charRgb,
  input  logic [RGB_W-1:0]           bkRgb,
`ifdef CURSOR_EN
  input  logic [$clog2(COLS)-1:0]    cursorSlot,
  input  logic                       cursorOn,
`endif
  output logic [$clog2(COLS)-1:0]    romSlot,
  output logic [$clog2(GLYPH_H)-1:0] romRow,
  input  logic [GLYPH_W-1:0]         romData,
  output logic [RGB_W-1:0]           vgaRGB
);

  localparam int SLOT_W  = $clog2(COLS);
  localparam int ROW_W   = $clog2(GLYPH_H);
  localparam int COL_W   = $clog2(GLYPH_W);
  localparam int DX_W    = SLOT_W + COL_W;
  localparam int HW      = PIX_W + 1;   // wide enough that xPos+W never wraps
  localparam int VW      = LINE_W + 1;
  localparam int BOX_PIX = COLS * GLYPH_W;
  localparam int LASTD   = ROM_LAT - 1;

  logic frameStart;
  logic flashPhase;

  flash_timer #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) uFlashTimer (
    .clock     (clock),
    .reset     (reset),
    .pixelCnt  (pixelCnt),
    .lineCnt   (lineCnt),
    .frameStart(frameStart),
    .flashPhase(flashPhase)
  );

  // Per-frame shadow copies of the geometry and flash controls.
  logic [PIX_W-1:0]  xPosS;
  logic [LINE_W-1:0] yPosS;
  logic [1:0]        magS;
  logic              flashEnS;

  // Values in force for the current pixel: the frame-start pixel sees the
  // freshly loaded inputs, all later pixels see the shadows.
  logic [PIX_W-1:0]  xEff;
  logic [LINE_W-1:0] yEff;
  logic [1:0]        magEff;
  logic              flashEnEff;

`ifdef CURSOR_EN
  logic [SLOT_W-1:0] cursorSlotS;
  logic              cursorOnS;
  logic [SLOT_W-1:0] cursorSlotEff;
  logic              cursorOnEff;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xPosS    <= '0;
      yPosS    <= '0;
      magS     <= '0;
      flashEnS <= 1'b0;
`ifdef CURSOR_EN
      cursorSlotS <= '0;
      cursorOnS   <= 1'b0;
`endif
    end else if (frameStart) begin
      xPosS    <= xPos;
      yPosS    <= yPos;
      magS     <= mag;
      flashEnS <= flashEn;
`ifdef CURSOR_EN
      cursorSlotS <= cursorSlot;
      cursorOnS   <= cursorOn;
`endif
    end
  end

  always_comb begin
    xEff       = xPosS;
    yEff       = yPosS;
    magEff     = magS;
    flashEnEff = flashEnS;
`ifdef CURSOR_EN
    cursorSlotEff = cursorSlotS;
    cursorOnEff   = cursorOnS;
`endif
    if (frameStart) begin
      xEff       = xPos;
      yEff       = yPos;
      magEff     = mag;
      flashEnEff = flashEn;
`ifdef CURSOR_EN
      cursorSlotEff = cursorSlot;
      cursorOnEff   = cursorOn;
`endif
    end
  end

  // Box geometry and glyph coordinates for the incoming pixel.
  logic [HW-1:0]     boxW;
  logic [HW-1:0]     xEnd;
  logic [VW-1:0]     boxH;
  logic [VW-1:0]     yEnd;
  logic              inBoxNow;
  logic [PIX_W-1:0]  dxOff;
  logic [LINE_W-1:0] dyOff;
  logic [DX_W-1:0]   dx;
  logic [SLOT_W-1:0] slotNow;
  logic [COL_W-1:0]  bitColNow;
  logic [ROW_W-1:0]  rowNow;

  assign boxW = HW'(BOX_PIX) << magEff;
  assign boxH = VW'(GLYPH_H) << magEff;
  assign xEnd = {1'b0, xEff} + boxW;
  assign yEnd = {1'b0, yEff} + boxH;

  assign inBoxNow = ({1'b0, pixelCnt} >= {1'b0, xEff}) && ({1'b0, pixelCnt} < xEnd) &&
                    ({1'b0, lineCnt}  >= {1'b0, yEff}) && ({1'b0, lineCnt}  < yEnd);

  // Offsets are only meaningful inside the box, where they fit the
  // truncated widths after the magnification shift.
  assign dxOff     = pixelCnt - xEff;
  assign dyOff     = lineCnt - yEff;
  assign dx        = DX_W'(dxOff >> magEff);
  assign rowNow    = ROW_W'(dyOff >> magEff);
  assign slotNow   = dx[COL_W +: SLOT_W];
  assign bitColNow = dx[COL_W-1:0];

`ifdef CURSOR_EN
  logic cursorNow;
  assign cursorNow = cursorOnEff && (slotNow == cursorSlotEff) &&
                     (rowNow == ROW_W'(GLYPH_H - 1)) && !flashPhase;
`endif

  // S0 register stage followed by ROM_LAT delay stages aligned with romData.
  logic                            validS0;
  logic                            inBoxS0;
  logic                            maskS0;
  logic [COL_W-1:0]                bitColS0;
  logic [ROM_LAT-1:0]              validD;
  logic [ROM_LAT-1:0]              inBoxD;
  logic [ROM_LAT-1:0]              maskD;
  logic [ROM_LAT-1:0][COL_W-1:0]   bitColD;
`ifdef CURSOR_EN
  logic                            cursorS0;
  logic [ROM_LAT-1:0]              cursorD;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validS0  <= 1'b0;
      inBoxS0  <= 1'b0;
      maskS0   <= 1'b0;
      bitColS0 <= '0;
      romSlot  <= '0;
      romRow   <= '0;
      validD   <= '0;
      inBoxD   <= '0;
      maskD    <= '0;
      bitColD  <= '0;
`ifdef CURSOR_EN
      cursorS0 <= 1'b0;
      cursorD  <= '0;
`endif
    end else begin
      validS0  <= 1'b1;
      inBoxS0  <= inBoxNow;
      maskS0   <= flashEnEff & flashPhase;
      bitColS0 <= bitColNow;
      // Outside the box the ROM address is left alone to avoid needless toggling.
      if (inBoxNow) begin
        romSlot <= slotNow;
        romRow  <= rowNow;
      end
      validD[0]  <= validS0;
      inBoxD[0]  <= inBoxS0;
      maskD[0]   <= maskS0;
      bitColD[0] <= bitColS0;
`ifdef CURSOR_EN
      cursorS0   <= cursorNow;
      cursorD[0] <= cursorS0;
`endif
      for (int i = 1; i < ROM_LAT; i++) begin
        validD[i]  <= validD[i-1];
        inBoxD[i]  <= inBoxD[i-1];
        maskD[i]   <= maskD[i-1];
        bitColD[i] <= bitColD[i-1];
`ifdef CURSOR_EN
        cursorD[i] <= cursorD[i-1];
`endif
      end
    end
  end

  // Output stage: pick the glyph bit (MSB is leftmost) and colour the pixel.
  logic [COL_W-1:0] bitSel;
  logic             fgHit;

  always_comb begin
    bitSel = COL_W'(GLYPH_W - 1) - bitColD[LASTD];
    fgHit  = inBoxD[LASTD] && romData[bitSel] && !maskD[LASTD];
`ifdef CURSOR_EN
    fgHit  = fgHit || (inBoxD[LASTD] && cursorD[LASTD]);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vgaRGB <= '0;
    end else if (!validD[LASTD]) begin
      vgaRGB <= '0;
    end else begin
      vgaRGB <= fgHit ? charRgb : bkRgb;
    end
  end

endmodule

// File: tb/tb_char_string_renderer.sv
// Self-checking bench for char_string_renderer: drives arbitrary raster
// sequences, models the glyph ROM, and compares every pixel against a
// behavioural per-pixel reference.
module tb_char_string_renderer;

  localparam int COLS         = 8;
  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int RGB_W        = 9;
  localparam int ROM_LAT      = 2;
  localparam int FLASH_FRAMES = 2;
  localparam int LAT          = ROM_LAT + 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [9:0]        pixelCnt;
  logic [8:0]        lineCnt;
  logic [9:0]        xPos;
  logic [8:0]        yPos;
  logic [1:0]        mag;
  logic              flashEn;
  logic [RGB_W-1:0]  charRgb;
  logic [RGB_W-1:0]  bkRgb;
  logic [2:0]        romSlot;
  logic [3:0]        romRow;
  logic [GLYPH_W-1:0] romData;
  logic [RGB_W-1:0]  vgaRGB;
`ifdef CURSOR_EN
  logic [2:0]        cursorSlot = '0;
  logic              cursorOn = 1'b0;
`endif

  always #5 clock = ~clock;

  char_string_renderer #(
    .COLS(COLS), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .RGB_W(RGB_W),
    .ROM_LAT(ROM_LAT), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clock(clock), .reset(reset), .pixelCnt(pixelCnt), .lineCnt(lineCnt),
    .xPos(xPos), .yPos(yPos), .mag(mag), .flashEn(flashEn),
    .charRgb(charRgb), .bkRgb(bkRgb),
`ifdef CURSOR_EN
    .cursorSlot(cursorSlot), .cursorOn(cursorOn),
`endif
    .romSlot(romSlot), .romRow(romRow), .romData(romData), .vgaRGB(vgaRGB)
  );

  // Glyph ROM: table lookup followed by ROM_LAT register stages.
  logic [GLYPH_W-1:0] romTable [COLS][GLYPH_H];
  logic [GLYPH_W-1:0] romPipe  [ROM_LAT];

  always @(posedge clock) begin
    romPipe[0] <= romTable[romSlot][romRow];
    for (int i = 1; i < ROM_LAT; i++) romPipe[i] <= romPipe[i-1];
  end
  assign romData = romPipe[ROM_LAT-1];

  int nChecks = 0;
  int nFail   = 0;

  task automatic checkEq(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  int sX, sY, sM, sFe;   // per-frame settings
  int nFrames;           // frame starts seen since reset
  int mSlot, mRow;       // last in-box ROM address
  int expQ[$];           // expected vgaRGB, oldest first

  task automatic applyPix(input int px, input int ln);
    int phase, scale, w, h, col, slot, b, row, rgb;
    logic [GLYPH_W-1:0] g;
    pixelCnt = 10'(px);
    lineCnt  = 9'(ln);
    phase = (nFrames / FLASH_FRAMES) % 2;
    if (px == 0 && ln == 0) begin
      sX = int'(xPos); sY = int'(yPos); sM = int'(mag); sFe = int'(flashEn);
      nFrames++;
    end
    scale = 1 << sM;
    w = COLS * GLYPH_W * scale;
    h = GLYPH_H * scale;
    rgb = int'(bkRgb);
    if (px >= sX && px < sX + w && ln >= sY && ln < sY + h) begin
      col  = (px - sX) / scale;
      slot = col / GLYPH_W;
      b    = col % GLYPH_W;
      row  = (ln - sY) / scale;
      mSlot = slot;
      mRow  = row;
      g = romTable[slot][row];
      if (g[GLYPH_W-1-b] && !(sFe != 0 && phase != 0)) rgb = int'(charRgb);
    end
    expQ.push_back(rgb);
  endtask

  task automatic step(input int px, input int ln);
    @(negedge clock);
    checkEq("romSlot", int'(romSlot), mSlot);
    checkEq("romRow", int'(romRow), mRow);
    if (expQ.size() >= LAT) checkEq("vgaRGB", int'(vgaRGB), expQ.pop_front());
    applyPix(px, ln);
  endtask

  task automatic scan(input int l0, input int l1, input int p0, input int p1);
    for (int l = l0; l <= l1; l++)
      for (int p = p0; p <= p1; p++)
        step(p, l);
  endtask

  // Holds reset for the given number of clock edges, then releases it on a
  // falling edge and presents the given pixel as the first one after release.
  task automatic doReset(input int cycles, input int px, input int ln);
    @(negedge clock);
    reset = 1'b1;
    pixelCnt = 10'(px);
    lineCnt  = 9'(ln);
    #1;
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) @(negedge clock);
      checkEq("rstRGB", int'(vgaRGB), 0);
      checkEq("rstSlot", int'(romSlot), 0);
      checkEq("rstRow", int'(romRow), 0);
    end
    @(negedge clock);
    checkEq("rstRGB", int'(vgaRGB), 0);
    reset = 1'b0;
    sX = 0; sY = 0; sM = 0; sFe = 0; nFrames = 0; mSlot = 0; mRow = 0;
    expQ.delete();
    for (int i = 0; i < LAT - 1; i++) expQ.push_back(0);
    applyPix(px, ln);
  endtask

  task automatic fillSlot0();
    for (int s = 0; s < COLS; s++)
      for (int r = 0; r < GLYPH_H; r++)
        romTable[s][r] = (s == 0) ? 8'hFF : 8'h00;
    expQ.delete();
  endtask

  task automatic fillConst(input logic [7:0] v);
    for (int s = 0; s < COLS; s++)
      for (int r = 0; r < GLYPH_H; r++)
        romTable[s][r] = v;
    expQ.delete();
  endtask

  task automatic fillRandom();
    for (int s = 0; s < COLS; s++)
      for (int r = 0; r < GLYPH_H; r++)
        romTable[s][r] = 8'($urandom);
    expQ.delete();
  endtask

  initial begin
    int px, ln, w;
    reset = 1'b1;
    pixelCnt = 10'd5; lineCnt = 9'd5;
    xPos = 10'd100; yPos = 9'd50; mag = 2'd0; flashEn = 1'b0;
    charRgb = 9'h1C7; bkRgb = 9'h038;
    fillSlot0();
    doReset(3, 5, 5);

    // Pre-frame pixels use the reset shadows (box at 0,0, 1x).
    scan(5, 5, 1, 20);

    // Slot 0 solid, 1x at (100,50).
    step(0, 0);
    scan(48, 67, 96, 112);

    // 4x magnification, single-pixel glyph column.
    fillConst(8'h80);
    mag = 2'd2; xPos = 10'd37; yPos = 9'd20;
    step(0, 0);
    scan(18, 30, 33, 300);
    scan(80, 86, 33, 60);

    // Flashing with a two-frame half period.
    fillSlot0();
    xPos = 10'd100; yPos = 9'd50; mag = 2'd0; flashEn = 1'b1;
    doReset(3, 5, 5);
    for (int f = 0; f < 6; f++) begin
      step(0, 0);
      scan(55, 56, 98, 110);
    end

    // Mid-frame xPos change only lands at the next frame start.
    flashEn = 1'b0; mag = 2'd2; xPos = 10'd100; yPos = 9'd150;
    step(0, 0);
    scan(190, 199, 95, 140);
    xPos = 10'd300;
    scan(200, 210, 95, 140);
    scan(200, 202, 295, 340);
    step(0, 0);
    scan(200, 203, 95, 140);
    scan(200, 203, 295, 340);

    // Box running off the right edge; next line starts clean.
    fillRandom();
    xPos = 10'd600; yPos = 9'd10; mag = 2'd1;
    step(0, 0);
    for (int l = 10; l <= 41; l++) begin
      scan(l, l, 590, 639);
      scan(l + 1, l + 1, 0, 10);
    end

    // Reset in the middle of the box.
    step(0, 0);
    scan(20, 20, 600, 620);
    doReset(3, 610, 20);
    scan(20, 20, 611, 639);
    scan(5, 6, 0, 70);
    step(0, 0);
    scan(12, 12, 600, 639);

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      fillRandom();
      xPos = 10'($urandom_range(0, 639));
      yPos = 9'($urandom_range(0, 399));
      mag = 2'($urandom_range(0, 3));
      flashEn = 1'($urandom_range(0, 1));
      charRgb = 9'($urandom);
      bkRgb = ~charRgb;
      step(0, 0);
      w = (COLS * GLYPH_W) << mag;
      for (int k = 0; k < 400; k++) begin
        if (k % 2 == 0) begin
          px = int'(xPos) - 3 + int'($urandom_range(0, w + 6));
          ln = int'(yPos) - 3 + int'($urandom_range(0, (GLYPH_H << mag) + 6));
        end else begin
          px = int'($urandom_range(0, 639));
          ln = int'($urandom_range(0, 399));
        end
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (ln < 0) ln = 0;
        if (ln > 399) ln = 399;
        if (px == 0 && ln == 0) px = 1;
        step(px, ln);
      end
    end

    // Drain the pipeline.
    for (int i = 0; i < LAT; i++) step(639, 399);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
